// File: rtl/ddr_pkg.sv
// Shared HDR-DDR definitions: lane mode codes, broadcast address, register-file
// window base and the CCC controller state encoding.
package ddr_pkg;

    localparam logic [2:0] TX_SPECIAL_PRE = 3'd0;
    localparam logic [2:0] TX_CMD         = 3'd1;
    localparam logic [2:0] TX_DATA_PRE    = 3'd2;
    localparam logic [2:0] TX_DATA        = 3'd3;
    localparam logic [2:0] TX_CRC         = 3'd4;
    localparam logic [2:0] TX_RESTART     = 3'd5;
    localparam logic [2:0] TX_EXIT        = 3'd6;

    localparam logic [2:0] RX_PRE  = 3'd0;
    localparam logic [2:0] RX_DATA = 3'd1;
    localparam logic [2:0] RX_CRC  = 3'd2;

    localparam logic [6:0] BCAST_ADDR    = 7'h7E;
    localparam logic [7:0] CCC_DATA_BASE = 8'h40;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD_PRE, S_CMD_WORD, S_DEF_PRE, S_DEF_WORD,
        S_DIR_RESTART, S_DIR_PRE, S_DIR_WORD,
        S_WR_PRE, S_WR_DATA, S_WR_CRC,
        S_RD_PRE, S_RD_DATA, S_RD_CRC,
        S_END, S_DONE
    } ccc_state_t;

    // Bytes are packed two per DDR word; 17 bits keeps 16'hFFFF from wrapping.
    function automatic logic [16:0] word_count(input logic [15:0] len);
        return ({1'b0, len} + 17'd1) >> 1;
    endfunction

endpackage

// File: rtl/ccc_word_counter.sv
// Remaining-word counter for the CCC data phase: load from a byte length,
// decrement per transferred word, flag zero and last-word.
module ccc_word_counter
    import ddr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [15:0] i_len,
    input  logic        i_dec,
    output logic        o_zero,
    output logic        o_last
);

    logic [16:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= word_count(i_len);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 17'd1;
        end
    end

    assign o_zero = (r_count == 17'd0);
    assign o_last = (r_count == 17'd1);

endmodule

// File: rtl/ccc_controller.sv
// HDR-DDR CCC engine: sequences command, optional defining byte, optional
// direct addressing and the data phase over the TX and RX lane engines.
module ccc_controller
    import ddr_pkg::*;
(
    input  logic        i_sys_clk,
    input  logic        i_sys_rst,
    input  logic        i_engine_en,
    input  logic        i_tx_mode_done,
    input  logic        i_rx_mode_done,
    input  logic        i_rx_error,
    input  logic        i_rx_nack,
    input  logic [7:0]  i_ccc_value,
    input  logic [7:0]  i_def_byte,
    input  logic        i_def_en,
    input  logic        i_direct,
    input  logic [6:0]  i_target_addr,
    input  logic        i_RnW,
    input  logic [15:0] i_data_len,
    input  logic        i_end_restart,
    output logic        o_tx_en,
    output logic [2:0]  o_tx_mode,
    output logic        o_rx_en,
    output logic [2:0]  o_rx_mode,
    output logic [7:0]  o_regf_addr,
    output logic        o_regf_rd_en,
    output logic        o_regf_wr_en,
    output logic        o_engine_done,
    output logic        o_error,
    output logic [3:0]  o_state
);

    // Lane handshake: o_*_en stays high for as long as a state owns that lane;
    // a single-cycle i_*_mode_done completes the state's work. A done pulse on
    // a lane that is not enabled is dropped.

    ccc_state_t r_state;
    ccc_state_t w_next_state;
    ccc_state_t w_data_state;
    ccc_state_t w_after_def;
    ccc_state_t w_after_cmd;

    logic       r_rst_q;
    logic [7:0] r_ccc_value;
    logic [7:0] r_def_byte;
    logic       r_def_en;
    logic       r_direct;
    logic [6:0] r_target_addr;
    logic       r_rnw;
    logic       r_end_restart;
    logic [7:0] r_regf_addr;
    logic       r_regf_rd_en;
    logic       r_error;

    logic w_start;
    logic w_tx_done;
    logic w_rx_done;
    logic w_rx_fault;
    logic w_rd_word;
    logic w_wr_word;
    logic w_cnt_zero;
    logic w_cnt_last;
    logic w_unused_capture;

    // A start is refused on the first edge after reset releases.
    assign w_start    = (r_state == S_IDLE) && i_engine_en && !r_rst_q;
    assign w_tx_done  = i_tx_mode_done && o_tx_en;
    assign w_rx_done  = i_rx_mode_done && o_rx_en;
    assign w_rx_fault = i_rx_error || ((r_state == S_RD_PRE) && i_rx_nack);
    assign w_rd_word  = (r_state == S_WR_DATA) && w_tx_done;
    assign w_wr_word  = (r_state == S_RD_DATA) && w_rx_done && !i_rx_error;

    assign w_data_state = w_cnt_zero ? S_END : (r_rnw ? S_RD_PRE : S_WR_PRE);
    assign w_after_def  = r_direct ? S_DIR_RESTART : w_data_state;
    assign w_after_cmd  = r_def_en ? S_DEF_PRE : w_after_def;

    ccc_word_counter u_word_counter (
        .i_clk  (i_sys_clk),
        .i_rst  (i_sys_rst),
        .i_load (w_start),
        .i_len  (i_data_len),
        .i_dec  (w_rd_word || w_wr_word),
        .o_zero (w_cnt_zero),
        .o_last (w_cnt_last)
    );

    always_ff @(posedge i_sys_clk) begin
        r_rst_q <= i_sys_rst;
        if (i_sys_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:        if (w_start)   w_next_state = S_CMD_PRE;
            S_CMD_PRE:     if (w_tx_done) w_next_state = S_CMD_WORD;
            S_CMD_WORD:    if (w_tx_done) w_next_state = w_after_cmd;
            S_DEF_PRE:     if (w_tx_done) w_next_state = S_DEF_WORD;
            S_DEF_WORD:    if (w_tx_done) w_next_state = w_after_def;
            S_DIR_RESTART: if (w_tx_done) w_next_state = S_DIR_PRE;
            S_DIR_PRE:     if (w_tx_done) w_next_state = S_DIR_WORD;
            S_DIR_WORD:    if (w_tx_done) w_next_state = w_data_state;
            S_WR_PRE:      if (w_tx_done) w_next_state = S_WR_DATA;
            S_WR_DATA:     if (w_tx_done && w_cnt_last) w_next_state = S_WR_CRC;
            S_WR_CRC:      if (w_tx_done) w_next_state = S_END;
            S_RD_PRE:      if (w_rx_done) w_next_state = w_rx_fault ? S_END : S_RD_DATA;
            S_RD_DATA: begin
                if (w_rx_done) begin
                    if (i_rx_error)      w_next_state = S_END;
                    else if (w_cnt_last) w_next_state = S_RD_CRC;
                end
            end
            S_RD_CRC:      if (w_rx_done) w_next_state = S_END;
            S_END:         if (w_tx_done) w_next_state = S_DONE;
            S_DONE:        w_next_state = S_IDLE;
            default:       w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_en   = 1'b0;
        o_tx_mode = 3'd0;
        o_rx_en   = 1'b0;
        o_rx_mode = 3'd0;
        case (r_state)
            S_CMD_PRE:     begin o_tx_en = 1'b1; o_tx_mode = TX_SPECIAL_PRE; end
            S_CMD_WORD:    begin o_tx_en = 1'b1; o_tx_mode = TX_CMD;         end
            S_DEF_PRE:     begin o_tx_en = 1'b1; o_tx_mode = TX_DATA_PRE;    end
            S_DEF_WORD:    begin o_tx_en = 1'b1; o_tx_mode = TX_DATA;        end
            S_DIR_RESTART: begin o_tx_en = 1'b1; o_tx_mode = TX_RESTART;     end
            S_DIR_PRE:     begin o_tx_en = 1'b1; o_tx_mode = TX_SPECIAL_PRE; end
            S_DIR_WORD:    begin o_tx_en = 1'b1; o_tx_mode = TX_CMD;         end
            S_WR_PRE:      begin o_tx_en = 1'b1; o_tx_mode = TX_DATA_PRE;    end
            S_WR_DATA:     begin o_tx_en = 1'b1; o_tx_mode = TX_DATA;        end
            S_WR_CRC:      begin o_tx_en = 1'b1; o_tx_mode = TX_CRC;         end
            S_RD_PRE:      begin o_rx_en = 1'b1; o_rx_mode = RX_PRE;         end
            S_RD_DATA:     begin o_rx_en = 1'b1; o_rx_mode = RX_DATA;        end
            S_RD_CRC:      begin o_rx_en = 1'b1; o_rx_mode = RX_CRC;         end
            S_END: begin
                o_tx_en   = 1'b1;
                o_tx_mode = r_end_restart ? TX_RESTART : TX_EXIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_ccc_value   <= '0;
            r_def_byte    <= '0;
            r_def_en      <= 1'b0;
            r_direct      <= 1'b0;
            r_target_addr <= '0;
            r_rnw         <= 1'b0;
            r_end_restart <= 1'b0;
            r_regf_addr   <= CCC_DATA_BASE;
            r_regf_rd_en  <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_regf_rd_en <= 1'b0;
            if (w_start) begin
                r_ccc_value   <= i_ccc_value;
                r_def_byte    <= i_def_byte;
                r_def_en      <= i_def_en;
                r_direct      <= i_direct;
                r_target_addr <= i_target_addr;
                r_rnw         <= i_RnW;
                r_end_restart <= i_end_restart;
                r_regf_addr   <= CCC_DATA_BASE;
                r_error       <= 1'b0;
            end
            // Fetch the first write word as WR_DATA is entered, then one per
            // accepted word while more remain.
            if ((r_state == S_WR_PRE) && w_tx_done) begin
                r_regf_rd_en <= 1'b1;
            end
            if (w_rd_word) begin
                r_regf_addr  <= r_regf_addr + 8'd1;
                r_regf_rd_en <= !w_cnt_last;
            end
            if (w_wr_word) begin
                r_regf_addr <= r_regf_addr + 8'd1;
            end
            if (w_rx_done && w_rx_fault) begin
                r_error <= 1'b1;
            end
        end
    end

    // Command payload fields are held for the lane engines' view of the
    // transaction but are not driven out of this block.
    assign w_unused_capture = ^{r_ccc_value, r_def_byte, r_target_addr};

    assign o_regf_addr   = r_regf_addr;
    assign o_regf_rd_en  = r_regf_rd_en;
    assign o_regf_wr_en  = w_wr_word;
    assign o_engine_done = (r_state == S_DONE);
    assign o_error       = r_error;
    assign o_state       = r_state;

endmodule

// File: tb/tb_ccc_controller.sv
// Bench for ccc_controller: lane responder with random latency and stray
// pulses, transaction-level expected sequences, directed and random cases.
module tb_ccc_controller;

    localparam logic [7:0] M_TX_SPRE = 8'd0, M_TX_CMD = 8'd1, M_TX_DPRE = 8'd2,
                           M_TX_DATA = 8'd3, M_TX_CRC = 8'd4, M_TX_RST = 8'd5,
                           M_TX_EXIT = 8'd6;
    localparam logic [7:0] M_RX_PRE = 8'd0, M_RX_DATA = 8'd1, M_RX_CRC = 8'd2;
    localparam int         BASE = 8'h40;

    logic        clk;
    logic        i_sys_rst;
    logic        i_engine_en;
    logic        i_tx_mode_done;
    logic        i_rx_mode_done;
    logic        i_rx_error;
    logic        i_rx_nack;
    logic [7:0]  i_ccc_value;
    logic [7:0]  i_def_byte;
    logic        i_def_en;
    logic        i_direct;
    logic [6:0]  i_target_addr;
    logic        i_RnW;
    logic [15:0] i_data_len;
    logic        i_end_restart;
    logic        o_tx_en;
    logic [2:0]  o_tx_mode;
    logic        o_rx_en;
    logic [2:0]  o_rx_mode;
    logic [7:0]  o_regf_addr;
    logic        o_regf_rd_en;
    logic        o_regf_wr_en;
    logic        o_engine_done;
    logic        o_error;
    logic [3:0]  o_state;

    ccc_controller dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (i_sys_rst),
        .i_engine_en    (i_engine_en),
        .i_tx_mode_done (i_tx_mode_done),
        .i_rx_mode_done (i_rx_mode_done),
        .i_rx_error     (i_rx_error),
        .i_rx_nack      (i_rx_nack),
        .i_ccc_value    (i_ccc_value),
        .i_def_byte     (i_def_byte),
        .i_def_en       (i_def_en),
        .i_direct       (i_direct),
        .i_target_addr  (i_target_addr),
        .i_RnW          (i_RnW),
        .i_data_len     (i_data_len),
        .i_end_restart  (i_end_restart),
        .o_tx_en        (o_tx_en),
        .o_tx_mode      (o_tx_mode),
        .o_rx_en        (o_rx_en),
        .o_rx_mode      (o_rx_mode),
        .o_regf_addr    (o_regf_addr),
        .o_regf_rd_en   (o_regf_rd_en),
        .o_regf_wr_en   (o_regf_wr_en),
        .o_engine_done  (o_engine_done),
        .o_error        (o_error),
        .o_state        (o_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int unsigned n_vec = 0;
    int unsigned n_miscmp = 0;

    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_wr_q[$];
    logic       exp_err;
    int         exp_words;

    logic [7:0] tx_log[$];
    logic [7:0] rx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_log[$];
    int         done_cnt;

    int unsigned max_delay = 0;
    bit          noise_en = 1'b0;
    int          rx_err_idx = -1;
    bit          rx_nack_inj = 1'b0;
    int          rx_idx = 0;
    int unsigned tx_wait = 0;
    int unsigned rx_wait = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cmp_q(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check_eq({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check_eq($sformatf("%s[%0d]", name, i), 32'(got[i]), 32'(exp[i]));
            if (got[i] !== exp[i]) break;
        end
    endtask

    // ---------------- lane responder and strobe monitor ----------------
    initial begin : lane_responder
        i_tx_mode_done = 1'b0;
        i_rx_mode_done = 1'b0;
        i_rx_error     = 1'b0;
        i_rx_nack      = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_mode_done = 1'b0;
            i_rx_mode_done = 1'b0;
            i_rx_error     = 1'b0;
            i_rx_nack      = 1'b0;
            if (!i_sys_rst) begin
                if (o_tx_en) begin
                    if (tx_wait == 0) begin
                        i_tx_mode_done = 1'b1;
                        tx_log.push_back(8'(o_tx_mode));
                        tx_wait = $urandom_range(0, max_delay);
                    end else begin
                        tx_wait--;
                    end
                    if (noise_en && $urandom_range(0, 3) == 0) begin
                        i_rx_mode_done = 1'b1;
                        i_rx_error     = 1'b1;
                        i_rx_nack      = 1'b1;
                    end
                end else if (o_rx_en) begin
                    if (rx_wait == 0) begin
                        i_rx_mode_done = 1'b1;
                        if (rx_idx == rx_err_idx) begin
                            if (rx_nack_inj) i_rx_nack = 1'b1;
                            else             i_rx_error = 1'b1;
                        end
                        rx_log.push_back(8'(o_rx_mode));
                        rx_idx++;
                        rx_wait = $urandom_range(0, max_delay);
                    end else begin
                        rx_wait--;
                    end
                    if (noise_en && $urandom_range(0, 3) == 0) i_tx_mode_done = 1'b1;
                end
            end
            #1;
            if (o_regf_rd_en)  rd_log.push_back(o_regf_addr);
            if (o_regf_wr_en)  wr_log.push_back(o_regf_addr);
            if (o_engine_done) done_cnt++;
        end
    end

    // ---------------- driver tasks and reference model ----------------
    task automatic set_cfg(input logic [7:0] ccc, input logic [7:0] defb, input logic def_en,
                           input logic direct, input logic [6:0] taddr, input logic rnw,
                           input logic [15:0] len, input logic restart,
                           input int err_idx, input logic nack);
        i_ccc_value   = ccc;
        i_def_byte    = defb;
        i_def_en      = def_en;
        i_direct      = direct;
        i_target_addr = taddr;
        i_RnW         = rnw;
        i_data_len    = len;
        i_end_restart = restart;
        rx_err_idx    = err_idx;
        rx_nack_inj   = nack;
        rx_idx        = 0;
        tx_log.delete(); rx_log.delete(); rd_log.delete(); wr_log.delete();
        done_cnt = 0;
        exp_tx_q.delete(); exp_rx_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
        exp_err   = 1'b0;
        exp_words = (int'(len) + 1) / 2;

        exp_tx_q.push_back(M_TX_SPRE);
        exp_tx_q.push_back(M_TX_CMD);
        if (def_en) begin
            exp_tx_q.push_back(M_TX_DPRE);
            exp_tx_q.push_back(M_TX_DATA);
        end
        if (direct) begin
            exp_tx_q.push_back(M_TX_RST);
            exp_tx_q.push_back(M_TX_SPRE);
            exp_tx_q.push_back(M_TX_CMD);
        end
        if (exp_words > 0 && !rnw) begin
            exp_tx_q.push_back(M_TX_DPRE);
            for (int i = 0; i < exp_words; i++) begin
                exp_tx_q.push_back(M_TX_DATA);
                exp_rd_q.push_back(8'(BASE + i));
            end
            exp_tx_q.push_back(M_TX_CRC);
        end else if (exp_words > 0) begin
            exp_rx_q.push_back(M_RX_PRE);
            if (err_idx == 0) begin
                exp_err = 1'b1;
            end else begin
                for (int i = 1; i <= exp_words; i++) begin
                    exp_rx_q.push_back(M_RX_DATA);
                    if (err_idx == i) begin
                        exp_err = 1'b1;
                        break;
                    end
                    exp_wr_q.push_back(8'(BASE + i - 1));
                end
                if (!exp_err) begin
                    exp_rx_q.push_back(M_RX_CRC);
                    if (err_idx == exp_words + 1) exp_err = 1'b1;
                end
            end
        end
        exp_tx_q.push_back(restart ? M_TX_RST : M_TX_EXIT);
    endtask

    // Called on the negedge after the start edge; scrambles the inputs and
    // waits for completion before scoring the transaction.
    task automatic finish_txn(input string name);
        int budget;
        int cyc;
        budget = (exp_words + 16) * (int'(max_delay) + 2) + 64;
        @(negedge clk);
        i_ccc_value   = 8'($urandom);
        i_def_byte    = 8'($urandom);
        i_def_en      = 1'($urandom);
        i_direct      = 1'($urandom);
        i_target_addr = 7'($urandom);
        i_RnW         = 1'($urandom);
        i_data_len    = 16'($urandom);
        i_end_restart = 1'($urandom);
        i_engine_en   = 1'($urandom);
        @(negedge clk);
        i_engine_en = 1'b0;
        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        if (done_cnt == 0) begin
            check_eq({name, ":done_timeout"}, 32'd0, 32'd1);
            @(negedge clk); i_sys_rst = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk); i_sys_rst = 1'b0;
            repeat (2) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq({name, ":done_pulses"}, done_cnt, 32'd1);
        check_eq({name, ":error"}, 32'(o_error), 32'(exp_err));
        check_eq({name, ":idle_tx_en"}, 32'(o_tx_en), 32'd0);
        check_eq({name, ":idle_rx_en"}, 32'(o_rx_en), 32'd0);
        cmp_q({name, ":tx_mode"}, tx_log, exp_tx_q);
        cmp_q({name, ":rx_mode"}, rx_log, exp_rx_q);
        cmp_q({name, ":rd_addr"}, rd_log, exp_rd_q);
        cmp_q({name, ":wr_addr"}, wr_log, exp_wr_q);
    endtask

    task automatic run_txn(input string name, input logic [7:0] ccc, input logic [7:0] defb,
                           input logic def_en, input logic direct, input logic [6:0] taddr,
                           input logic rnw, input logic [15:0] len, input logic restart,
                           input int err_idx, input logic nack);
        @(negedge clk);
        set_cfg(ccc, defb, def_en, direct, taddr, rnw, len, restart, err_idx, nack);
        i_engine_en = 1'b1;
        finish_txn(name);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ":tx_en"},     32'(o_tx_en),       32'd0);
        check_eq({tag, ":tx_mode"},   32'(o_tx_mode),     32'd0);
        check_eq({tag, ":rx_en"},     32'(o_rx_en),       32'd0);
        check_eq({tag, ":rx_mode"},   32'(o_rx_mode),     32'd0);
        check_eq({tag, ":regf_addr"}, 32'(o_regf_addr),   32'h40);
        check_eq({tag, ":rd_en"},     32'(o_regf_rd_en),  32'd0);
        check_eq({tag, ":wr_en"},     32'(o_regf_wr_en),  32'd0);
        check_eq({tag, ":done"},      32'(o_engine_done), 32'd0);
        check_eq({tag, ":error"},     32'(o_error),       32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int cyc;
        int words_r;
        int err_r;
        logic [15:0] len_r;
        logic rnw_r;

        i_sys_rst = 1'b1;
        i_engine_en = 1'b0;
        set_cfg(8'h01, 8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 16'd0, 1'b0, -1, 1'b0);
        i_engine_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");

        // Start held high through reset release: first edge must not start.
        @(negedge clk);
        i_sys_rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("no_start_on_release", 32'(o_tx_en), 32'd0);
        @(posedge clk);
        #1;
        check_eq("start_after_release_en", 32'(o_tx_en), 32'd1);
        check_eq("start_after_release_mode", 32'(o_tx_mode), 32'd0);
        finish_txn("bcast_01");

        max_delay = 2;
        noise_en  = 1'b1;
        run_txn("dir_wr_len5", 8'h89, 8'h5A, 1'b1, 1'b1, 7'h22, 1'b0, 16'd5, 1'b1, -1, 1'b0);
        run_txn("dir_rd_err",  8'h8B, 8'h00, 1'b0, 1'b1, 7'h31, 1'b1, 16'd4, 1'b0, 2, 1'b0);
        run_txn("dir_rd_nack", 8'h8B, 8'h00, 1'b0, 1'b1, 7'h31, 1'b1, 16'd4, 1'b0, 0, 1'b1);

        // Reset in the middle of a write data phase.
        @(negedge clk);
        set_cfg(8'h8C, 8'h00, 1'b0, 1'b0, 7'h10, 1'b0, 16'd40, 1'b0, -1, 1'b0);
        i_engine_en = 1'b1;
        @(negedge clk);
        i_engine_en = 1'b0;
        cyc = 0;
        while (rd_log.size() < 3 && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        check_eq("mid_rst_reached_wr_data", 32'(rd_log.size() >= 3), 32'd1);
        @(negedge clk);
        i_sys_rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        i_sys_rst = 1'b0;
        repeat (2) @(posedge clk);
        run_txn("after_rst", 8'h90, 8'hA5, 1'b1, 1'b0, 7'h05, 1'b0, 16'd3, 1'b0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            max_delay = $urandom_range(0, 3);
            len_r   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 600))
                                                   : 16'($urandom_range(0, 12));
            rnw_r   = 1'($urandom);
            words_r = (int'(len_r) + 1) / 2;
            err_r   = (rnw_r && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, words_r + 1)) : -1;
            run_txn($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), 1'($urandom),
                    1'($urandom), 7'($urandom), rnw_r, len_r, 1'($urandom),
                    err_r, (err_r == 0) ? 1'($urandom) : 1'b0);
        end

        // Maximum length: 32768 words, address wraps past 8'hFF.
        max_delay = 0;
        run_txn("len_ffff", 8'h88, 8'h00, 1'b0, 1'b0, 7'h00, 1'b0, 16'hFFFF, 1'b0, -1, 1'b0);
        if (rd_log.size() > 192) begin
            check_eq("wrap_ff", 32'(rd_log[191]), 32'hFF);
            check_eq("wrap_00", 32'(rd_log[192]), 32'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
